// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO controller bus: consumer request, FIFO status/memory inputs,
// and the pop/pointer/data outputs of the controller.
interface fifo_rd_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              en;
    logic              empty;
    logic [DATA_W-1:0] mem_rdata;
    logic              pop;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              underflow;

    modport master (
        input  en, empty, mem_rdata,
        output pop, rd_addr, rd_ptr, dout, dout_valid, underflow
    );

    modport slave (
        output en, empty, mem_rdata,
        input  pop, rd_addr, rd_ptr, dout, dout_valid, underflow
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: read pointer, guarded pop strobe, registered data/valid,
// sticky underflow. Define FIFO_RD_GRAY_PTR_EN for a Gray-coded rd_ptr output.
module fifo_rd_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           arst,
    fifo_rd_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMPTY = 2'd1,
        POP   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   ptr_bin;
    logic [ADDR_W:0]   ptr_nxt;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;
    logic              underflow_q;
    logic              pop_int;

    // Empty guard is combinational so a word taken last cycle is never popped twice.
    assign pop_int = (state == POP) && !bus.empty;
    assign ptr_nxt = ptr_bin + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= IDLE;
            ptr_bin     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.empty)
                state <= EMPTY;
            else if (bus.en)
                state <= POP;
            else
                state <= IDLE;

            if (pop_int) begin
                ptr_bin <= ptr_nxt;
                dout_q  <= bus.mem_rdata;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end

            if ((state == POP) && bus.empty)
                underflow_q <= 1'b1;
        end
    end

`ifdef FIFO_RD_GRAY_PTR_EN
    logic [ADDR_W:0] ptr_gray;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            ptr_gray <= '0;
        else if (pop_int)
            ptr_gray <= ptr_nxt ^ (ptr_nxt >> 1);
    end

    assign bus.rd_ptr = ptr_gray;
`else
    assign bus.rd_ptr = ptr_bin;
`endif

    assign bus.pop        = pop_int;
    assign bus.rd_addr    = ptr_bin[ADDR_W-1:0];
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.underflow  = underflow_q;
endmodule
